// File: rtl/router_pkg.sv
// Shared router definitions: default datapath geometry and the flit type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

    localparam int ROUTER_DATA_W   = 64;
    localparam int ROUTER_NUM_VC   = 2;
    localparam int ROUTER_VC_DEPTH = 4;

    // VC index width and per-VC occupancy width (must be able to hold DEPTH itself)
    localparam int VC_IDX_W = $clog2(ROUTER_NUM_VC);
    localparam int CNT_W    = $clog2(ROUTER_VC_DEPTH) + 1;

    typedef logic [ROUTER_DATA_W-1:0] flit_t;

endpackage

// File: rtl/router_vc_fifo.sv
// Single-VC circular FIFO with explicit occupancy count; all-zero entries are ordinary data.
// Latency: rdata_o shows the head entry combinationally; push visible at head one edge later.
// Backpressure: push ignored when full, pop ignored when empty; full/empty come from registered count.
//
// Ports: clk, reset (async, active-high), push_i, pop_i, wdata_i -> rdata_o, count_o, full_o, empty_o.
module router_vc_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so the pointer increment wraps DEPTH-1 -> 0 by itself.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: stale entries are unreachable once the count is cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/router_vc_input_buffer.sv
// Router input port: NUM_VC independent DEPTH-deep flit FIFOs with decoupled write/read VC select.
// Latency: flit pushed at edge N appears on registered data_out after edge N+1; no bypass.
// Backpressure: ready[v] = VC not full (registered count only); blocked stalls pops only, writes continue.
//
// Ports: clk, reset (async, active-high), send/wr_vc/data_in (write side), rd_vc/blocked (read side),
//        ready, data_out/out_valid (registered), vc_count (VC0 in LSBs), overflow_err.
// Optional: define ROUTER_VC_IB_ERR_EN for sticky per-VC write-when-full flags; otherwise tied to 0.
module router_vc_input_buffer
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W,
    parameter int NUM_VC = ROUTER_NUM_VC,
    parameter int DEPTH  = ROUTER_VC_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                send,
    input  logic [$clog2(NUM_VC)-1:0]           wr_vc,
    input  logic [DATA_W-1:0]                   data_in,
    input  logic [$clog2(NUM_VC)-1:0]           rd_vc,
    input  logic                                blocked,
    output logic [NUM_VC-1:0]                   ready,
    output logic [DATA_W-1:0]                   data_out,
    output logic                                out_valid,
    output logic [NUM_VC*($clog2(DEPTH)+1)-1:0] vc_count,
    output logic [NUM_VC-1:0]                   overflow_err
);

    localparam int VW = $clog2(NUM_VC);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] rdata [NUM_VC];
    logic [CW-1:0]     cnt   [NUM_VC];
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        router_vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (send && (wr_vc == VW'(v))),
            .pop_i   (!blocked && (rd_vc == VW'(v))),
            .wdata_i (data_in),
            .rdata_o (rdata[v]),
            .count_o (cnt[v]),
            .full_o  (full[v]),
            .empty_o (empty[v])
        );
        assign ready[v]                 = !full[v];
        assign vc_count[v*CW +: CW]     = cnt[v];
    end

    // Output register: holds the popped flit for one cycle, zero otherwise.
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;

    always_comb begin
        data_out_d  = '0;
        out_valid_d = 1'b0;
        if (!blocked && !empty[rd_vc]) begin
            data_out_d  = rdata[rd_vc];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

`ifdef ROUTER_VC_IB_ERR_EN
    // Sticky until reset: a refused write to a full VC is a protocol violation upstream.
    logic [NUM_VC-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (send && full[wr_vc]) err_d[wr_vc] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end

    assign overflow_err = err_q;
`else
    assign overflow_err = '0;
`endif

endmodule

// File: tb/tb_router_vc_input_buffer.sv
module tb_router_vc_input_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        send;
    logic [0:0]  wr_vc;
    logic [63:0] data_in;
    logic [0:0]  rd_vc;
    logic        blocked;
    logic [1:0]  ready;
    logic [63:0] data_out;
    logic        out_valid;
    logic [5:0]  vc_count;
    logic [1:0]  overflow_err;

    router_vc_input_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .send         (send),
        .wr_vc        (wr_vc),
        .data_in      (data_in),
        .rd_vc        (rd_vc),
        .blocked      (blocked),
        .ready        (ready),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .vc_count     (vc_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per VC plus the expected registered outputs.
    logic [63:0] mq0[$];
    logic [63:0] mq1[$];
    logic [63:0] exp_dout;
    logic        exp_vld;
    logic [1:0]  exp_err;
    logic        chk_en;

    int total = 0;
    int bad   = 0;

    function automatic int qsize(input int v);
        return (v == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [5:0] exp_cnt();
        return {3'(mq1.size()), 3'(mq0.size())};
    endfunction

    function automatic logic [1:0] exp_rdy();
        return {mq1.size() != 4, mq0.size() != 4};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        exp_dout = '0;
        exp_vld  = 1'b0;
        exp_err  = '0;
    endtask

    // Apply one cycle of stimulus, advance the model at the edge, return in the low phase.
    task automatic step(input logic s, input int wv, input logic [63:0] d,
                        input int rv, input logic blk);
        int sw;
        send    = s;
        wr_vc   = 1'(wv);
        data_in = d;
        rd_vc   = 1'(rv);
        blocked = blk;
        @(posedge clk);
        sw = qsize(wv);
        if (!blk && qsize(rv) > 0) begin
            exp_vld  = 1'b1;
            exp_dout = (rv == 0) ? mq0.pop_front() : mq1.pop_front();
        end else begin
            exp_vld  = 1'b0;
            exp_dout = '0;
        end
        if (s) begin
            if (sw < 4) begin
                if (wv == 0) mq0.push_back(d);
                else         mq1.push_back(d);
            end else begin
`ifdef ROUTER_VC_IB_ERR_EN
                exp_err[wv] = 1'b1;
`endif
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 64'h0, 0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("out_valid", 64'(out_valid), 64'(exp_vld));
            chk("data_out", data_out, exp_dout);
            chk("vc_count", 64'(vc_count), 64'(exp_cnt()));
            chk("ready", 64'(ready), 64'(exp_rdy()));
            chk("overflow_err", 64'(overflow_err), 64'(exp_err));
        end
    end

    initial begin
        logic [1:0] err_lit;
        chk_en  = 1'b0;
        reset   = 1'b1;
        send    = 1'b0;
        wr_vc   = '0;
        data_in = '0;
        rd_vc   = '0;
        blocked = 1'b1;
        model_clear();
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_ready", 64'(ready), 64'h3);
        chk("rst_vc_count", 64'(vc_count), 64'h0);
        chk("rst_ovf", 64'(overflow_err), 64'h0);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        #1;

        // 1: reset mid-stream, checked before any further clock edge
        for (int i = 0; i < 3; i++) step(1'b1, 0, 64'hC0 + 64'(i), 0, 1'b1);
        step(1'b0, 0, 64'h0, 0, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'h1);
        #1 reset = 1'b1;
        #1;
        chk("amid_out_valid", 64'(out_valid), 64'h0);
        chk("amid_data_out", data_out, 64'h0);
        chk("amid_ready", 64'(ready), 64'h3);
        chk("amid_vc_count", 64'(vc_count), 64'h0);
        model_clear();
        reset = 1'b0;

        // 2: all-zero flit is real data
        step(1'b1, 1, 64'h0, 1, 1'b0);
        step(1'b0, 0, 64'h0, 1, 1'b0);
        chk("zero_valid", 64'(out_valid), 64'h1);
        chk("zero_data", data_out, 64'h0);
        chk("zero_cnt1", 64'(vc_count[5:3]), 64'h0);

        // 3: fill and wrap VC0
        for (int i = 0; i < 4; i++) step(1'b1, 0, 64'hA0 + 64'(i), 0, 1'b1);
        chk("full_ready0", 64'(ready[0]), 64'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 0, 64'h0, 0, 1'b0);
            chk("wrap_seq", data_out, 64'hA0 + 64'(i));
        end
        step(1'b1, 0, 64'hA4, 0, 1'b1);
        step(1'b1, 0, 64'hA5, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 0, 64'h0, 0, 1'b0);
            if (i < 4) chk("wrap_seq", data_out, 64'hA2 + 64'(i));
            else       chk("wrap_empty", 64'(out_valid), 64'h0);
        end

        // 4: blocked stalls reads only
        for (int i = 0; i < 4; i++) step(1'b1, 1, 64'hC0 + 64'(i), 1, 1'b1);
        chk("blk_cnt1", 64'(vc_count[5:3]), 64'h4);
        chk("blk_ready1", 64'(ready[1]), 64'h0);
        chk("blk_valid", 64'(out_valid), 64'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 64'h0, 1, 1'b0);
            chk("blk_seq", data_out, 64'hC0 + 64'(i));
        end

        // 5: push into full VC alongside a pop of the same VC
        for (int i = 0; i < 4; i++) step(1'b1, 0, 64'hD0 + 64'(i), 0, 1'b1);
        step(1'b1, 0, 64'hBB, 0, 1'b0);
        chk("fpp_data", data_out, 64'hD0);
        chk("fpp_cnt0", 64'(vc_count[2:0]), 64'h3);
`ifdef ROUTER_VC_IB_ERR_EN
        err_lit = 2'b01;
`else
        err_lit = 2'b00;
`endif
        chk("fpp_ovf", 64'(overflow_err), 64'(err_lit));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0, 64'h0, 0, 1'b0);
            chk("fpp_drain", data_out, 64'hD1 + 64'(i));
        end

        // 6: VC independence
        step(1'b1, 0, 64'h10, 0, 1'b1);
        step(1'b1, 1, 64'h20, 0, 1'b1);
        step(1'b1, 0, 64'h11, 0, 1'b1);
        step(1'b1, 1, 64'h21, 0, 1'b1);
        chk("ind_cnt", 64'(vc_count), 64'h12);
        step(1'b0, 0, 64'h0, 1, 1'b0);
        chk("ind_rd1", data_out, 64'h20);
        chk("ind_cnt_a", 64'(vc_count), 64'h0A);
        step(1'b0, 0, 64'h0, 0, 1'b0);
        chk("ind_rd0", data_out, 64'h10);
        chk("ind_cnt_b", 64'(vc_count), 64'h09);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) d = '0;
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 1)), d,
                 int'($urandom_range(0, 1)), $urandom_range(0, 9) < 3);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
